hub75_panel_rx: RTL

// - Panel-side receiver for the HUB75 scan bus driven by the matrix drivers (RGB1/RGB2, ADDR, CLK, LAT, OE).
// - Oversamples the bus on the system clock, shifts column data, and commits a line pair to an internal frame buffer on LAT.
// - Provides a pixel read port for loopback checking and panel emulation.
// - Reports per-line column count and protocol errors.

---
 rtl/hub75_panel_rx.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/hub75_panel_rx.sv
// -----------------------------------------------------------------------------
// hub75_panel_rx
//
// Panel-side receiver for a HUB75 scan bus. The bus is oversampled on the
// system clock. Column data is shifted into a top-half and a bottom-half
// shift register. A LAT rising edge commits both registers into an internal
// frame buffer. The buffer holds 2*2**ADDR_W rows of COLS pixels, 3 bits each.
//
// Optional feature macro: HUB75_RX_OE_STATS_EN
//   When defined, the number of cycles with OE active (low) is counted per
//   line and published on oe_last_o at each commit. When undefined,
//   oe_last_o is tied to 0.
//
// Ports
//   clk_i        system clock, at least 4x the panel shift clock
//   rst_i        asynchronous active-high reset
//   pclk_i       panel shift clock; a rising edge shifts one pixel in
//   lat_i        latch; a rising edge commits the shift registers
//   oe_i         output enable, active low (does not gate capture)
//   addr_i       row-pair address
//   rgb1_i       top-half pixel {R,G,B}
//   rgb2_i       bottom-half pixel {R,G,B}
//   rd_row_i     read row; rows >= 2**ADDR_W are the bottom half
//   rd_col_i     read column
//   rd_rgb_o     pixel at {rd_row_i, rd_col_i}, one cycle of latency
//   line_done_o  one-cycle pulse on the cycle after a commit
//   line_addr_o  address captured at the last commit
//   col_count_o  shifts seen before the last commit, saturating at 127
//   err_clr_i    clears the sticky error flags
//   err_short_o  sticky: a commit happened with fewer than COLS shifts
//   err_over_o   sticky: a commit happened with more than COLS shifts
//   oe_last_o    OE-active cycles counted in the previous line
// -----------------------------------------------------------------------------
module hub75_panel_rx #(
   parameter int COLS        = 64,
   parameter int ADDR_W      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              pclk_i,
   input  logic              lat_i,
   input  logic              oe_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [2:0]        rgb1_i,
   input  logic [2:0]        rgb2_i,
   input  logic [ADDR_W:0]   rd_row_i,
   input  logic [5:0]        rd_col_i,
   output logic [2:0]        rd_rgb_o,
   output logic              line_done_o,
   output logic [ADDR_W-1:0] line_addr_o,
   output logic [6:0]        col_count_o,
   input  logic              err_clr_i,
   output logic              err_short_o,
   output logic              err_over_o,
   output logic [15:0]       oe_last_o
);

   localparam int SW    = 9 + ADDR_W;          // pclk, lat, oe, addr, rgb1, rgb2
   localparam int NROWS = 2 * (2 ** ADDR_W);
   localparam int LW    = 3 * COLS;

   // ---------------------------------------------------------------------------
   // Input synchronizers. All bus signals travel through the same chain, so
   // the data stays aligned with the PCLK edge seen at the last stage.
   // ---------------------------------------------------------------------------
   logic [SW-1:0] sync_q [SYNC_STAGES];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= {pclk_i, lat_i, oe_i, addr_i, rgb1_i, rgb2_i};
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   logic              s_pclk;
   logic              s_lat;
   logic              s_oe;
   logic [ADDR_W-1:0] s_addr;
   logic [2:0]        s_rgb1;
   logic [2:0]        s_rgb2;

   assign {s_pclk, s_lat, s_oe, s_addr, s_rgb1, s_rgb2} = sync_q[SYNC_STAGES-1];

   // One extra delayed copy of the last stage for edge detection.
   logic pclk_dly_q;
   logic lat_dly_q;
   logic pclk_rise;
   logic commit;

   assign pclk_rise = s_pclk & ~pclk_dly_q;
   assign commit    = s_lat  & ~lat_dly_q;

   // ---------------------------------------------------------------------------
   // Shift path. Column c occupies bits [3c+2:3c]. A new pixel enters at the
   // top (column COLS-1), so after COLS shifts the first pixel is in column 0.
   // The next-state values feed the commit directly. A shift and a commit in
   // the same cycle therefore commit the line including the new pixel.
   // ---------------------------------------------------------------------------
   logic [LW-1:0] top_q, top_d;
   logic [LW-1:0] bot_q, bot_d;
   logic [6:0]    cnt_q, cnt_d;

   always_comb begin
      top_d = top_q;
      bot_d = bot_q;
      cnt_d = cnt_q;
      if (pclk_rise) begin
         top_d = {s_rgb1, top_q[LW-1:3]};
         bot_d = {s_rgb2, bot_q[LW-1:3]};
         if (cnt_q != 7'd127) begin
            cnt_d = cnt_q + 7'd1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Frame buffer and commit outputs. The buffer is cleared by reset, so it is
   // built from registers rather than a RAM primitive.
   // ---------------------------------------------------------------------------
   logic [LW-1:0]     fb_q [NROWS];
   logic              line_done_q;
   logic [ADDR_W-1:0] line_addr_q;
   logic [6:0]        col_count_q;
   logic              err_short_q;
   logic              err_over_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pclk_dly_q  <= 1'b0;
         lat_dly_q   <= 1'b0;
         top_q       <= '0;
         bot_q       <= '0;
         cnt_q       <= '0;
         line_done_q <= 1'b0;
         line_addr_q <= '0;
         col_count_q <= '0;
         err_short_q <= 1'b0;
         err_over_q  <= 1'b0;
         for (int r = 0; r < NROWS; r++) begin
            fb_q[r] <= '0;
         end
      end else begin
         pclk_dly_q  <= s_pclk;
         lat_dly_q   <= s_lat;
         top_q       <= top_d;
         bot_q       <= bot_d;
         line_done_q <= commit;

         // When a commit sets a flag in the same cycle as err_clr_i, the
         // set wins.
         err_short_q <= (err_short_q & ~err_clr_i) | (commit & (cnt_d < 7'(COLS)));
         err_over_q  <= (err_over_q  & ~err_clr_i) | (commit & (cnt_d > 7'(COLS)));

         if (commit) begin
            fb_q[{1'b0, s_addr}] <= top_d;
            fb_q[{1'b1, s_addr}] <= bot_d;
            col_count_q          <= cnt_d;
            line_addr_q          <= s_addr;
            cnt_q                <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Read port. It reads the pre-update buffer, so a row committed in the same
   // cycle returns its old contents. Columns at or above COLS never match the
   // mux and read back as 0.
   // ---------------------------------------------------------------------------
   logic [LW-1:0] rd_line;
   logic [2:0]    rd_pix;
   logic [2:0]    rd_rgb_q;

   assign rd_line = fb_q[rd_row_i];

   always_comb begin
      rd_pix = '0;
      for (int c = 0; c < COLS; c++) begin
         if (rd_col_i == 6'(c)) begin
            rd_pix = rd_line[3*c +: 3];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_rgb_q <= '0;
      end else begin
         rd_rgb_q <= rd_pix;
      end
   end

   // ---------------------------------------------------------------------------
   // Optional OE statistics
   // ---------------------------------------------------------------------------
`ifdef HUB75_RX_OE_STATS_EN
   logic [15:0] oe_cnt_q, oe_cnt_d;
   logic [15:0] oe_last_q;

   always_comb begin
      oe_cnt_d = oe_cnt_q;
      if (!s_oe && oe_cnt_q != 16'hFFFF) begin
         oe_cnt_d = oe_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         oe_cnt_q  <= '0;
         oe_last_q <= '0;
      end else if (commit) begin
         oe_last_q <= oe_cnt_d;
         oe_cnt_q  <= '0;
      end else begin
         oe_cnt_q  <= oe_cnt_d;
      end
   end

   assign oe_last_o = oe_last_q;
`else
   logic oe_unused;
   assign oe_unused = s_oe;
   assign oe_last_o = '0;
`endif

   assign rd_rgb_o    = rd_rgb_q;
   assign line_done_o = line_done_q;
   assign line_addr_o = line_addr_q;
   assign col_count_o = col_count_q;
   assign err_short_o = err_short_q;
   assign err_over_o  = err_over_q;

endmodule
